terminal_writer: RTL and testbench

- Parametrised terminal text engine: accepts a character stream, maintains the cursor, and drives the character-grid RAM that feeds character_sprite.
- Generalises the button-driven cursor logic in top_level: valid/ready input, control codes, full-screen clear, and either hardware scroll or wrap-with-line-clear at the bottom row.

---
 rtl/term_pkg.sv | 31 +++
 rtl/terminal_writer_copier.sv | 101 ++++++++++
 rtl/terminal_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_terminal_writer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// term_pkg: shared definitions for the terminal text engine.
//   - term_state_t : engine FSM states
//   - CH_*         : control codes the engine understands
//   - CH_PRINT_*   : inclusive bounds of the printable character range
//   - is_printable : range test on a zero-extended character code
package term_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCROLL,
    SCROLL_DRAIN,
    LINE_CLEAR
  } term_state_t;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  localparam logic [7:0] CH_PRINT_MIN = 8'h20;
  localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

  // Codes wider than 8 bits are compared in full, so anything above 0xFF is
  // never treated as printable.
  function automatic logic is_printable(input logic [31:0] code);
    return (code >= 32'(CH_PRINT_MIN)) && (code <= 32'(CH_PRINT_MAX));
  endfunction

endpackage

// File: rtl/terminal_writer_copier.sv
// grid_row_copier: moves every grid row up by one row during a scroll.
// For a = 0 .. W*(H-1)-1 it reads cell a+W and, once the read data returns
// READ_LATENCY cycles later, writes it to cell a. One read per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse that begins a copy
//   rd_addr / rd_data   grid read port (data READ_LATENCY cycles after addr)
//   issuing             high while reads are still being issued
//   wr_en/wr_addr/wr_data  registered grid write port
//   idle                no reads pending, pipeline empty, no write in flight
module grid_row_copier #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int ADDR_W        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  issuing,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  idle
);

  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(SCREEN_WIDTH * (SCREEN_HEIGHT - 1) - 1);

  logic                    issuing_q;
  logic [ADDR_W-1:0]       dst_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  // Read issue side: the destination counter and the read address advance
  // together, the read address always one row ahead of the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issuing_q <= 1'b0;
      dst_q     <= '0;
      rd_addr_q <= '0;
    end else if (start) begin
      issuing_q <= 1'b1;
      dst_q     <= '0;
      rd_addr_q <= W_A;
    end else if (issuing_q) begin
      if (dst_q == COPY_LAST) begin
        issuing_q <= 1'b0;
      end else begin
        dst_q     <= dst_q + 1'b1;
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  // Delay line carrying the destination address alongside the outstanding
  // read, so the write lines up with the data when it returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_addr_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= issuing_q;
      pipe_addr_q[0] <= dst_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  // Write side: capture returning read data together with its destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= pipe_vld_q[READ_LATENCY-1];
      if (pipe_vld_q[READ_LATENCY-1]) begin
        wr_addr_q <= pipe_addr_q[READ_LATENCY-1];
        wr_data_q <= rd_data;
      end
    end
  end

  assign rd_addr = rd_addr_q;
  assign issuing = issuing_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign idle    = !issuing_q && (pipe_vld_q == '0) && !wr_en_q;

endmodule

// File: rtl/terminal_writer.sv
// terminal_writer: terminal text engine driving the character-grid RAM.
// Accepts a valid/ready character stream, tracks the cursor, handles
// backspace / newline / carriage return / form feed, clears the screen and
// either scrolls (WRAP_MODE=0) or wraps and clears row 0 (WRAP_MODE=1) when
// a newline leaves the bottom row.
// Optional feature macro: TERMINAL_TAB_EN (0x09 advances to the next tab stop
// every 4 columns; without it 0x09 is ignored).
// Ports:
//   clk_in, rst_in               clock, asynchronous active-low reset
//   char_in/char_valid_in/char_ready_out  character stream
//   clear_in                     pulse: clear screen and home cursor
//   tg_write_en_out/tg_addr_out/tg_data_out  registered grid write port
//   tg_rd_addr_out/tg_rd_data_in grid read port, used by scrolling only
//   cursor_x_out/cursor_y_out    cursor column/row
//   busy_out                     engine is not in IDLE
module terminal_writer #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRAP_MODE     = 0
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic [DATA_WIDTH-1:0]                        char_in,
  input  logic                                         char_valid_in,
  output logic                                         char_ready_out,
  input  logic                                         clear_in,
  output logic                                         tg_write_en_out,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr_out,
  output logic [DATA_WIDTH-1:0]                        tg_data_out,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_rd_addr_out,
  input  logic [DATA_WIDTH-1:0]                        tg_rd_data_in,
  output logic [$clog2(SCREEN_WIDTH)-1:0]              cursor_x_out,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]             cursor_y_out,
  output logic                                         busy_out
);

  import term_pkg::*;

  localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int XW     = $clog2(SCREEN_WIDTH);
  localparam int YW     = $clog2(SCREEN_HEIGHT);

  localparam logic [ADDR_W-1:0] W_A           = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] CELLS_LAST    = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST     = ADDR_W'(SCREEN_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(SCREEN_WIDTH * (SCREEN_HEIGHT - 1));
  localparam logic [XW-1:0]     X_LAST        = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST        = YW'(SCREEN_HEIGHT - 1);

  term_state_t state_q, state_d;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     cur_addr;
  logic                  do_newline;
  logic                  copy_start;

  logic                  cp_issuing;
  logic                  cp_idle;
  logic                  cp_wr_en;
  logic [ADDR_W-1:0]     cp_wr_addr;
  logic [DATA_WIDTH-1:0] cp_wr_data;

  assign cur_addr = ADDR_W'(y_q) * W_A + ADDR_W'(x_q);

`ifdef TERMINAL_TAB_EN
  // Next tab stop strictly to the right of the cursor, one bit wider so it
  // can be compared against the last column without wrapping.
  logic [XW:0] tab_next;
  assign tab_next = ({1'b0, x_q} | (XW+1)'(3)) + 1'b1;
`endif

  grid_row_copier #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .DATA_WIDTH    (DATA_WIDTH),
    .READ_LATENCY  (READ_LATENCY),
    .ADDR_W        (ADDR_W)
  ) u_copier (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .start   (copy_start),
    .rd_data (tg_rd_data_in),
    .rd_addr (tg_rd_addr_out),
    .issuing (cp_issuing),
    .wr_en   (cp_wr_en),
    .wr_addr (cp_wr_addr),
    .wr_data (cp_wr_data),
    .idle    (cp_idle)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Cursor, write port and sweep counters. The write port is always driven
  // from these registers so every write lands the cycle after its decision.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
    end
  end

  // Next-state and datapath decisions. In IDLE a character is only taken
  // when clear_in is low, so a simultaneous clear always wins. Printable
  // characters in the last column, newline and (optionally) tab in the last
  // column share the newline action at the bottom of the block.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    copy_start = 1'b0;
    do_newline = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_in) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (char_valid_in) begin
          if (is_printable(32'(char_in))) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = char_in;
            if (x_q == X_LAST) do_newline = 1'b1;
            else               x_d = x_q + 1'b1;
          end else if (char_in == DATA_WIDTH'(CH_BS)) begin
            // Stepping back one cell is always cur_addr-1, including the
            // wrap from column 0 to the end of the previous row.
            if (x_q != '0) begin
              x_d       = x_q - 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr - 1'b1;
              wr_data_d = '0;
            end else if (y_q != '0) begin
              x_d       = X_LAST;
              y_d       = y_q - 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr - 1'b1;
              wr_data_d = '0;
            end
          end else if (char_in == DATA_WIDTH'(CH_LF)) begin
            do_newline = 1'b1;
          end else if (char_in == DATA_WIDTH'(CH_CR)) begin
            x_d = '0;
          end else if (char_in == DATA_WIDTH'(CH_FF)) begin
            state_d = CLEAR;
            cnt_d   = '0;
`ifdef TERMINAL_TAB_EN
          end else if (char_in == DATA_WIDTH'(CH_TAB)) begin
            if (x_q == X_LAST)                 do_newline = 1'b1;
            else if (tab_next > {1'b0, X_LAST}) x_d = X_LAST;
            else                               x_d = tab_next[XW-1:0];
`endif
          end
        end

        if (do_newline) begin
          x_d = '0;
          if (y_q != Y_LAST) begin
            y_d = y_q + 1'b1;
          end else if (WRAP_MODE == 0) begin
            state_d    = SCROLL;
            copy_start = 1'b1;
          end else begin
            y_d     = '0;
            state_d = LINE_CLEAR;
            cnt_d   = '0;
            base_d  = '0;
          end
        end
      end

      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        if (cnt_q == CELLS_LAST) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SCROLL: begin
        if (!cp_issuing) state_d = SCROLL_DRAIN;
      end

      SCROLL_DRAIN: begin
        if (cp_idle) begin
          state_d = LINE_CLEAR;
          cnt_d   = '0;
          base_d  = LAST_ROW_BASE;
        end
      end

      LINE_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + cnt_q;
        wr_data_d = '0;
        if (cnt_q == LINE_LAST) state_d = IDLE;
        else                    cnt_d = cnt_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs. Ready is also held low while reset is asserted. The engine and
  // the copier never write in the same cycle, so the copier's strobe selects.
  always_comb begin
    char_ready_out  = rst_in && (state_q == IDLE) && !clear_in;
    busy_out        = (state_q != IDLE);
    tg_write_en_out = wr_en_q | cp_wr_en;
    tg_addr_out     = cp_wr_en ? cp_wr_addr : wr_addr_q;
    tg_data_out     = cp_wr_en ? cp_wr_data : wr_data_q;
    cursor_x_out    = x_q;
    cursor_y_out    = y_q;
  end

endmodule

// File: tb/tb_terminal_writer.sv
// tb_terminal_writer: directed bench for terminal_writer. Two instances share
// clock and reset: dut0 scrolls (WRAP_MODE=0) behind a 2-cycle-latency grid
// RAM model, dut1 wraps (WRAP_MODE=1). Expected grid writes are queued as
// stimulus is driven and matched against the write port as it fires.
module tb_terminal_writer;

  localparam int W     = 76;
  localparam int H     = 44;
  localparam int RL    = 2;
  localparam int CELLS = W * H;
  localparam int AW    = $clog2(CELLS);
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]    char0 = '0, char1 = '0;
  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic          clear0 = 1'b0, clear1 = 1'b0;
  logic          ready0, ready1, wen0, wen1, busy0, busy1;
  logic [AW-1:0] addr0, addr1, rdaddr0, rdaddr1;
  logic [7:0]    data0, data1, rddata0;
  logic [7:0]    rddata1 = '0;
  logic [XW-1:0] cx0, cx1;
  logic [YW-1:0] cy0, cy1;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_cyc0 = 0, prev_cyc0 = 0;
  bit  mon0_en = 1'b1;
  bit  preload = 1'b0;
  wr_t q0[$];
  wr_t q1[$];

  logic [7:0] mem [CELLS];
  logic [7:0] img [CELLS];
  logic [7:0] rd_pipe [RL];

  always #5 clk = ~clk;

  terminal_writer #(.WRAP_MODE(0)) dut0 (
    .clk_in(clk), .rst_in(rst_n),
    .char_in(char0), .char_valid_in(valid0), .char_ready_out(ready0), .clear_in(clear0),
    .tg_write_en_out(wen0), .tg_addr_out(addr0), .tg_data_out(data0),
    .tg_rd_addr_out(rdaddr0), .tg_rd_data_in(rddata0),
    .cursor_x_out(cx0), .cursor_y_out(cy0), .busy_out(busy0)
  );

  terminal_writer #(.WRAP_MODE(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n),
    .char_in(char1), .char_valid_in(valid1), .char_ready_out(ready1), .clear_in(clear1),
    .tg_write_en_out(wen1), .tg_addr_out(addr1), .tg_data_out(data1),
    .tg_rd_addr_out(rdaddr1), .tg_rd_data_in(rddata1),
    .cursor_x_out(cx1), .cursor_y_out(cy1), .busy_out(busy1)
  );

  // Row-tagged fill pattern used before the scroll test.
  function automatic logic [7:0] pat(input int a);
    return 8'((a / W) * 3 + (a % W) + 1);
  endfunction

  // Grid RAM model for dut0: writes land on the clock edge, reads return
  // RL cycles after the address is presented.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= pat(i);
    end else if (wen0 && rst_n) begin
      mem[addr0] <= data0;
    end
    rd_pipe[0] <= mem[rdaddr0];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rddata0 = rd_pipe[RL-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && mon0_en && wen0) begin
      if (q0.size() == 0) begin
        checkOutput("dut0_unexpected_write", 32'(addr0), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q0.pop_front();
        checkOutput("dut0_wr_addr", 32'(addr0), 32'(e.addr));
        checkOutput("dut0_wr_data", 32'(data0), 32'(e.data));
        prev_cyc0 = last_cyc0;
        last_cyc0 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wen1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_write", 32'(addr1), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q1.pop_front();
        checkOutput("dut1_wr_addr", 32'(addr1), 32'(e.addr));
        checkOutput("dut1_wr_data", 32'(data1), 32'(e.data));
      end
    end
  end

  task automatic pushExp(input int which, input int a, input logic [7:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  // Present one character (and optionally clear) for exactly one clock edge.
  task automatic applyStimulus(input int which, input logic [7:0] c, input logic clr);
    if (which == 0) begin char0 = c; valid0 = 1'b1; clear0 = clr; end
    else            begin char1 = c; valid1 = 1'b1; clear1 = clr; end
    @(posedge clk); #1;
    valid0 = 1'b0; clear0 = 1'b0;
    valid1 = 1'b0; clear1 = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle(input int which, input int budget, output int n, output bit ready_seen);
    n = 0;
    ready_seen = 1'b0;
    while (((which == 0) ? busy0 : busy1) && n < budget) begin
      if ((which == 0) ? ready0 : ready1) ready_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wait_idle_timeout", 32'((which == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic waitDrain(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    idleCycles(3);
    checkOutput("scoreboard_drain", 32'((which == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  task automatic checkCursor(input int which, input string tag, input int ex, input int ey);
    checkOutput({tag, "_x"}, 32'((which == 0) ? cx0 : cx1), 32'(ex));
    checkOutput({tag, "_y"}, 32'((which == 0) ? cy0 : cy1), 32'(ey));
  endtask

  initial begin
    int  n;
    int  bad;
    bit  rdy;
    logic [7:0] ch;

    // Reset state.
    #2;
    checkOutput("reset_write_en", 32'(wen0), 32'd0);
    checkOutput("reset_ready", 32'(ready0), 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_rd_addr", 32'(rdaddr0), 32'd0);
    checkCursor(0, "reset_cursor0", 0, 0);
    checkCursor(1, "reset_cursor1", 0, 0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("ready_after_reset", 32'(ready0), 32'd1);

    // 'A','B' back to back.
    pushExp(0, 0, 8'h41);
    pushExp(0, 1, 8'h42);
    applyStimulus(0, 8'h41, 1'b0);
    applyStimulus(0, 8'h42, 1'b0);
    checkOutput("b_write_visible", 32'(wen0), 32'd1);
    checkOutput("b_write_addr", 32'(addr0), 32'd1);
    checkCursor(0, "after_ab", 2, 0);
    waitDrain(0, 20);
    checkOutput("ab_consecutive_cycles", 32'(last_cyc0 - prev_cyc0), 32'd1);

    // Backspace across a row boundary, then at home.
    applyStimulus(0, 8'h0D, 1'b0);
    applyStimulus(0, 8'h0A, 1'b0);
    checkCursor(0, "at_row1", 0, 1);
    pushExp(0, 75, 8'h00);
    applyStimulus(0, 8'h08, 1'b0);
    checkCursor(0, "bs_wrap", 75, 0);
    applyStimulus(0, 8'h0D, 1'b0);
    applyStimulus(0, 8'h08, 1'b0);
    checkCursor(0, "bs_home", 0, 0);
    waitDrain(0, 20);

    // A full row of printables ends with the newline action.
    for (int i = 0; i < W; i++) begin
      ch = 8'h30 + 8'(i % 64);
      pushExp(0, i, ch);
      applyStimulus(0, ch, 1'b0);
    end
    checkCursor(0, "full_row", 0, 1);
    waitDrain(0, 20);

    // Printable range edges; out-of-range and tab codes are ignored.
    pushExp(0, W, 8'h20);
    pushExp(0, W + 1, 8'h7E);
    applyStimulus(0, 8'h20, 1'b0);
    applyStimulus(0, 8'h7E, 1'b0);
    applyStimulus(0, 8'h7F, 1'b0);
    applyStimulus(0, 8'h1F, 1'b0);
    applyStimulus(0, 8'h09, 1'b0);
    checkCursor(0, "range_edges", 2, 1);
    waitDrain(0, 20);

    // Clear together with a valid 'Z': clear wins.
    for (int a = 0; a < CELLS; a++) pushExp(0, a, 8'h00);
    char0 = 8'h5A; valid0 = 1'b1; clear0 = 1'b1;
    #1;
    checkOutput("clear_blocks_ready", 32'(ready0), 32'd0);
    @(posedge clk); #1;
    valid0 = 1'b0; clear0 = 1'b0;
    waitIdle(0, 5000, n, rdy);
    checkOutput("clear_busy_cycles", 32'(n), 32'(CELLS));
    checkCursor(0, "after_clear", 0, 0);
    waitDrain(0, 20);

    // Scroll: preload row-tagged contents, park the cursor at (5,43), newline.
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    for (int i = 0; i < CELLS; i++) img[i] = pat(i);
    for (int i = 0; i < H - 1; i++) applyStimulus(0, 8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ch = 8'h61 + 8'(i);
      img[(H - 1) * W + i] = ch;
      pushExp(0, (H - 1) * W + i, ch);
      applyStimulus(0, ch, 1'b0);
    end
    checkCursor(0, "before_scroll", 5, H - 1);
    waitDrain(0, 20);
    for (int a = 0; a < (H - 1) * W; a++) pushExp(0, a, img[a + W]);
    for (int a = (H - 1) * W; a < CELLS; a++) pushExp(0, a, 8'h00);
    applyStimulus(0, 8'h0A, 1'b0);
    waitIdle(0, 5000, n, rdy);
    checkOutput("scroll_ready_low", 32'(rdy), 32'd0);
    checkCursor(0, "after_scroll", 0, H - 1);
    waitDrain(0, 20);
    bad = 0;
    for (int a = 0; a < CELLS; a++) begin
      if (mem[a] !== ((a < (H - 1) * W) ? img[a + W] : 8'h00)) bad++;
    end
    checkOutput("scroll_image_mismatches", 32'(bad), 32'd0);

    // Wrap mode on dut1: row 0 is cleared and the cursor homes.
    for (int i = 0; i < H - 1; i++) applyStimulus(1, 8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ch = 8'h71 + 8'(i);
      pushExp(1, (H - 1) * W + i, ch);
      applyStimulus(1, ch, 1'b0);
    end
    checkCursor(1, "wrap_before", 5, H - 1);
    for (int a = 0; a < W; a++) pushExp(1, a, 8'h00);
    applyStimulus(1, 8'h0A, 1'b0);
    checkCursor(1, "wrap_cursor_now", 0, 0);
    waitIdle(1, 500, n, rdy);
    checkOutput("wrap_busy_cycles", 32'(n), 32'(W));
    checkCursor(1, "wrap_after", 0, 0);
    waitDrain(1, 20);

    // Reset in the middle of a scroll.
    mon0_en = 1'b0;
    applyStimulus(0, 8'h0A, 1'b0);
    idleCycles(100);
    checkOutput("scroll_writing_before_reset", 32'(wen0), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_write_en", 32'(wen0), 32'd0);
    checkOutput("midreset_busy", 32'(busy0), 32'd0);
    checkOutput("midreset_rd_addr", 32'(rdaddr0), 32'd0);
    checkCursor(0, "midreset_cursor", 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete();
    mon0_en = 1'b1;
    idleCycles(1);
    pushExp(0, 0, 8'h51);
    applyStimulus(0, 8'h51, 1'b0);
    checkCursor(0, "after_midreset_char", 1, 0);
    waitDrain(0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
